// File: rtl/riscv_pkg.sv
// Shared core definitions: architectural widths and the write-back source encoding.
package riscv_pkg;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;

    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10
    } result_src_e;

endpackage

// File: rtl/wb_regfile_if.sv
// Write-back bundle from MEM/WB plus the decode read ports of the integer register file.
interface wb_regfile_if #(
    parameter int XLEN = riscv_pkg::XLEN,
    parameter int AW   = $clog2(riscv_pkg::NREGS)
);
    // No backpressure: every cycle the bundle is present, and RegWriteW alone qualifies a commit.
    logic [XLEN-1:0] ALUResultW;
    logic [XLEN-1:0] ReadDataW;
    logic [XLEN-1:0] PCPlus4W;
    logic [AW-1:0]   RdW;
    logic            RegWriteW;
    logic [1:0]      ResultSrcW;
    logic [AW-1:0]   A1;
    logic [AW-1:0]   A2;
    logic [XLEN-1:0] RD1;
    logic [XLEN-1:0] RD2;
    logic [XLEN-1:0] ResultW;
    logic [31:0]     WrCount;

    modport master (
        output ALUResultW, ReadDataW, PCPlus4W, RdW, RegWriteW, ResultSrcW, A1, A2,
        input  RD1, RD2, ResultW, WrCount
    );

    modport slave (
        input  ALUResultW, ReadDataW, PCPlus4W, RdW, RegWriteW, ResultSrcW, A1, A2,
        output RD1, RD2, ResultW, WrCount
    );
endinterface

// File: rtl/result_mux3.sv
// Write-back source select: ALU result, load data or link value; the reserved code yields zero.
module result_mux3
    import riscv_pkg::*;
#(
    parameter int W = XLEN
) (
    input  logic [1:0]   sel,
    input  logic [W-1:0] in_alu,
    input  logic [W-1:0] in_mem,
    input  logic [W-1:0] in_pc4,
    output logic [W-1:0] out
);
    always_comb begin
        out = '0;
        case (sel)
            RES_ALU: out = in_alu;
            RES_MEM: out = in_mem;
            RES_PC4: out = in_pc4;
            default: out = '0;
        endcase
    end
endmodule

// File: rtl/wb_regfile.sv
// Write-back stage: selects ResultW, commits it to the integer register file and
// serves two decode read ports with write-through bypass of the in-flight commit.
module wb_regfile #(
    parameter int XLEN  = riscv_pkg::XLEN,
    parameter int NREGS = riscv_pkg::NREGS
) (
    input  logic         clk,
    input  logic         reset,
    wb_regfile_if.slave  bus
);
    localparam int AW = $clog2(NREGS);

    logic [XLEN-1:0] regs [NREGS];
    logic [XLEN-1:0] result;
    logic [31:0]     wr_count;
    logic            commit;

    result_mux3 #(.W(XLEN)) u_result_mux (
        .sel    (bus.ResultSrcW),
        .in_alu (bus.ALUResultW),
        .in_mem (bus.ReadDataW),
        .in_pc4 (bus.PCPlus4W),
        .out    (result)
    );

    // Gating on reset also disables the bypass while reset is held.
    assign commit = reset && bus.RegWriteW && (bus.RdW != '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
            wr_count <= '0;
        end else begin
            if (commit) begin
                regs[bus.RdW] <= result;
            end
            // Writes to x0 still retire as write-class instructions.
            if (bus.RegWriteW) begin
                wr_count <= wr_count + 32'd1;
            end
        end
    end

    function automatic logic [XLEN-1:0] read_port(input logic [AW-1:0] addr);
        if (addr == '0) begin
            return '0;
        end else if (commit && (addr == bus.RdW)) begin
            return result;
        end else begin
            return regs[addr];
        end
    endfunction

    always_comb begin
        bus.RD1 = read_port(bus.A1);
        bus.RD2 = read_port(bus.A2);
    end

    assign bus.ResultW = result;
    assign bus.WrCount = wr_count;
endmodule

// File: tb/tb_wb_regfile.sv
// Directed and randomized checks of wb_regfile against a behavioural register-file model.
module tb_wb_regfile;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    // Reference state: architectural register contents and retired-write count.
    logic [31:0] model_regs [32];
    logic [31:0] model_count;

    wb_regfile_if #(.XLEN(32), .AW(5)) bus ();

    wb_regfile dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_result();
        case (bus.ResultSrcW)
            2'd0:    return bus.ALUResultW;
            2'd1:    return bus.ReadDataW;
            2'd2:    return bus.PCPlus4W;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] exp_read(input logic [4:0] a);
        if (a == 5'd0 || !reset) return 32'd0;
        if (bus.RegWriteW && bus.RdW != 5'd0 && a == bus.RdW) return exp_result();
        return model_regs[a];
    endfunction

    task automatic drive(input logic we, input logic [1:0] src, input logic [4:0] rd,
                         input logic [31:0] alu, input logic [31:0] mem, input logic [31:0] pc4,
                         input logic [4:0] a1, input logic [4:0] a2);
        bus.RegWriteW  = we;
        bus.ResultSrcW = src;
        bus.RdW        = rd;
        bus.ALUResultW = alu;
        bus.ReadDataW  = mem;
        bus.PCPlus4W   = pc4;
        bus.A1         = a1;
        bus.A2         = a2;
    endtask

    task automatic check_model(input string tag);
        #1;
        chk({tag, ".rd1"},    bus.RD1,     exp_read(bus.A1));
        chk({tag, ".rd2"},    bus.RD2,     exp_read(bus.A2));
        chk({tag, ".result"}, bus.ResultW, exp_result());
        chk({tag, ".count"},  bus.WrCount, model_count);
    endtask

    // One clock: update the model with what the edge commits, return at the next falling edge.
    task automatic tick();
        @(posedge clk);
        if (reset && bus.RegWriteW && bus.RdW != 5'd0) model_regs[bus.RdW] = exp_result();
        if (reset && bus.RegWriteW) model_count = model_count + 32'd1;
        @(negedge clk);
    endtask

    task automatic clear_model();
        for (int i = 0; i < 32; i++) model_regs[i] = 32'd0;
        model_count = 32'd0;
    endtask

    task automatic random_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            logic [4:0] rd;
            rd = 5'($urandom_range(0, 31));
            drive(($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), rd,
                  $urandom, $urandom, $urandom,
                  ($urandom_range(0, 1) != 0) ? rd : 5'($urandom_range(0, 31)),
                  ($urandom_range(0, 1) != 0) ? rd : 5'($urandom_range(0, 31)));
            check_model("rand");
            tick();
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        clear_model();
        reset  = 1'b0;
        drive(1'b1, 2'd0, 5'd5, 32'h0000_AAAA, 32'd0, 32'd0, 5'd5, 5'd5);

        // Bundle presented during reset is dropped; ResultW still follows inputs.
        @(negedge clk);
        #1;
        chk("rst.rd1", bus.RD1, 32'd0);
        chk("rst.count", bus.WrCount, 32'd0);
        chk("rst.result", bus.ResultW, 32'h0000_AAAA);
        tick();
        reset = 1'b1;
        drive(1'b0, 2'd0, 5'd5, 32'd0, 32'd0, 32'd0, 5'd5, 5'd0);
        #1;
        chk("rst_rel.rd1", bus.RD1, 32'd0);
        chk("rst_rel.count", bus.WrCount, 32'd0);

        // Commit with same-cycle bypass, then array read.
        drive(1'b1, 2'd0, 5'd3, 32'hDEAD_BEEF, 32'd0, 32'd0, 5'd3, 5'd0);
        #1;
        chk("byp.rd1", bus.RD1, 32'hDEAD_BEEF);
        chk("byp.rd2_x0", bus.RD2, 32'd0);
        tick();
        drive(1'b0, 2'd0, 5'd3, 32'd0, 32'd0, 32'd0, 5'd3, 5'd3);
        #1;
        chk("arr.rd1", bus.RD1, 32'hDEAD_BEEF);
        chk("arr.rd2", bus.RD2, 32'hDEAD_BEEF);
        chk("arr.count", bus.WrCount, 32'd1);

        // x0 write: never visible, still counted.
        drive(1'b1, 2'd0, 5'd0, 32'h0000_1234, 32'd0, 32'd0, 5'd0, 5'd0);
        #1;
        chk("x0.rd1", bus.RD1, 32'd0);
        chk("x0.result", bus.ResultW, 32'h0000_1234);
        tick();
        drive(1'b0, 2'd0, 5'd0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0);
        #1;
        chk("x0.rd1_after", bus.RD1, 32'd0);
        chk("x0.count", bus.WrCount, 32'd2);

        // Source select, including the reserved code.
        drive(1'b0, 2'd1, 5'd0, 32'h1111_1111, 32'h0000_0055, 32'h0000_0104, 5'd0, 5'd0);
        #1;
        chk("sel.mem", bus.ResultW, 32'h0000_0055);
        drive(1'b0, 2'd2, 5'd0, 32'h1111_1111, 32'h0000_0055, 32'h0000_0104, 5'd0, 5'd0);
        #1;
        chk("sel.pc4", bus.ResultW, 32'h0000_0104);
        drive(1'b0, 2'd3, 5'd0, 32'h1111_1111, 32'h0000_0055, 32'h0000_0104, 5'd0, 5'd0);
        #1;
        chk("sel.rsvd", bus.ResultW, 32'd0);

        // Reserved select with RegWriteW writes zero over a live value.
        @(negedge clk);
        drive(1'b1, 2'd0, 5'd9, 32'h0000_0077, 32'd0, 32'd0, 5'd9, 5'd0);
        tick();
        drive(1'b1, 2'd3, 5'd9, 32'hFFFF_FFFF, 32'd0, 32'd0, 5'd0, 5'd9);
        #1;
        chk("rsvd.byp", bus.RD2, 32'd0);
        tick();
        drive(1'b0, 2'd0, 5'd0, 32'd0, 32'd0, 32'd0, 5'd9, 5'd0);
        #1;
        chk("rsvd.arr", bus.RD1, 32'd0);
        chk("rsvd.count", bus.WrCount, 32'd4);

        // Dual bypass and back-to-back overwrite of x7.
        drive(1'b1, 2'd0, 5'd7, 32'h0000_0001, 32'd0, 32'd0, 5'd7, 5'd7);
        #1;
        chk("dual1.rd1", bus.RD1, 32'h0000_0001);
        chk("dual1.rd2", bus.RD2, 32'h0000_0001);
        tick();
        drive(1'b1, 2'd0, 5'd7, 32'h0000_0002, 32'd0, 32'd0, 5'd7, 5'd7);
        #1;
        chk("dual2.rd1", bus.RD1, 32'h0000_0002);
        chk("dual2.rd2", bus.RD2, 32'h0000_0002);
        tick();
        drive(1'b0, 2'd0, 5'd7, 32'h0000_0003, 32'd0, 32'd0, 5'd7, 5'd7);
        #1;
        chk("dual.arr1", bus.RD1, 32'h0000_0002);
        chk("dual.arr2", bus.RD2, 32'h0000_0002);

        random_cycles(400);

        // Counter wrap from the all-ones value.
        drive(1'b0, 2'd0, 5'd0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0);
        force dut.wr_count = 32'hFFFF_FFFF;
        #1;
        release dut.wr_count;
        model_count = 32'hFFFF_FFFF;
        #1;
        chk("wrap.pre", bus.WrCount, 32'hFFFF_FFFF);
        @(negedge clk);
        drive(1'b1, 2'd0, 5'd0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0);
        tick();
        drive(1'b0, 2'd0, 5'd0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0);
        #1;
        chk("wrap.post", bus.WrCount, 32'd0);

        // Asynchronous reset mid-cycle, no clock edge needed.
        drive(1'b1, 2'd0, 5'd12, 32'h0000_CAFE, 32'd0, 32'd0, 5'd12, 5'd0);
        tick();
        drive(1'b0, 2'd0, 5'd12, 32'h0BAD_F00D, 32'd0, 32'd0, 5'd12, 5'd7);
        #1;
        chk("ares.pre", bus.RD1, 32'h0000_CAFE);
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("ares.rd1", bus.RD1, 32'd0);
        chk("ares.rd2", bus.RD2, 32'd0);
        chk("ares.count", bus.WrCount, 32'd0);
        chk("ares.result", bus.ResultW, 32'h0BAD_F00D);
        clear_model();
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("ares.rel_rd1", bus.RD1, 32'd0);
        chk("ares.rel_rd2", bus.RD2, 32'd0);

        random_cycles(200);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
